// File: rtl/mc_pkg.sv
// Shared control-unit definitions: state encoding, opcodes, datapath select codes.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_FETCH   = 4'd0;
  localparam state_t ST_DECODE  = 4'd1;
  localparam state_t ST_MEMADR  = 4'd2;
  localparam state_t ST_LBRD    = 4'd3;
  localparam state_t ST_LBWR    = 4'd4;
  localparam state_t ST_SBWR    = 4'd5;
  localparam state_t ST_RTYPEEX = 4'd6;
  localparam state_t ST_RTYPEWR = 4'd7;
  localparam state_t ST_BEQEX   = 4'd8;
  localparam state_t ST_BNEEX   = 4'd9;
  localparam state_t ST_ADDIEX  = 4'd10;
  localparam state_t ST_ADDIWR  = 4'd11;
  localparam state_t ST_JEX     = 4'd12;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_INC    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // State entered from DECODE for a given opcode; unknown opcodes return to FETCH.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LB, OP_SB: decode_next = ST_MEMADR;
      OP_RTYPE:     decode_next = ST_RTYPEEX;
      OP_BEQ:       decode_next = ST_BEQEX;
      OP_BNE:       decode_next = ST_BNEEX;
      OP_ADDI:      decode_next = ST_ADDIEX;
      OP_J:         decode_next = ST_JEX;
      default:      decode_next = ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_fetch_seq.sv
// Instruction fetch beat sequencer: counts bus beats and steers each completed
// beat into its slice of the instruction register.
module mc_fetch_seq #(
  parameter int IRBEATS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               memready,
  output logic [IRBEATS-1:0] irwrite,
  output logic               last_beat
);

  localparam int BW = (IRBEATS > 1) ? $clog2(IRBEATS) : 1;

  logic [BW-1:0] beat_q, beat_d;

  // Advance on each completed beat, wrap after the last; irwrite only on completion.
  always_comb begin
    beat_d    = beat_q;
    irwrite   = '0;
    last_beat = (beat_q == BW'(IRBEATS - 1));
    if (reset) begin
      beat_d = '0;
    end else if (fetch_en && memready) begin
      irwrite = IRBEATS'(1) << beat_q;
      beat_d  = last_beat ? '0 : beat_q + BW'(1);
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) beat_q <= beat_d;

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM with multi-beat fetch and memory ready stalls.
module mc_controller
  import mc_pkg::*;
#(
  parameter int BUSW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic                 zero,
  input  logic                 memready,
  output logic                 memread,
  output logic                 memwrite,
  output logic                 alusrca,
  output logic                 memtoreg,
  output logic                 iord,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 pcen,
  output logic [1:0]           pcsource,
  output logic [1:0]           alusrcb,
  output logic [1:0]           aluop,
  output logic [32/BUSW-1:0]   irwrite,
  output logic                 illegal
);

  localparam int IRBEATS = 32 / BUSW;

  state_t state_q, state_d;
  logic   last_beat;

  mc_fetch_seq #(.IRBEATS(IRBEATS)) u_fetch (
    .clk      (clk),
    .reset    (reset),
    .fetch_en (state_q == ST_FETCH),
    .memready (memready),
    .irwrite  (irwrite),
    .last_beat(last_beat)
  );

  // Next-state: memory states hold until memready, others advance unconditionally.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH:   if (memready && last_beat) state_d = ST_DECODE;
        ST_DECODE:  state_d = decode_next(op);
        ST_MEMADR:  state_d = (op == OP_SB) ? ST_SBWR : ST_LBRD;
        ST_LBRD:    if (memready) state_d = ST_LBWR;
        ST_SBWR:    if (memready) state_d = ST_FETCH;
        ST_RTYPEEX: state_d = ST_RTYPEWR;
        ST_ADDIEX:  state_d = ST_ADDIWR;
        default:    state_d = ST_FETCH;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) state_q <= state_d;

  // Moore-style controls per state; pcen in FETCH and branches also depends on inputs.
  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    iord     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcen     = 1'b0;
    pcsource = PCSRC_ALU;
    alusrcb  = SRCB_REG;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          memread = 1'b1;
          alusrcb = SRCB_INC;
          pcen    = memready;
        end
        ST_DECODE: begin
          alusrcb = SRCB_BRANCH;
          illegal = (decode_next(op) == ST_FETCH);
        end
        ST_MEMADR, ST_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluop   = ALUOP_ADD;
        end
        ST_LBRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        ST_LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        ST_SBWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
        end
        ST_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        ST_RTYPEWR: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        ST_ADDIWR: regwrite = 1'b1;
        ST_BEQEX, ST_BNEEX: begin
          alusrca  = 1'b1;
          aluop    = ALUOP_SUB;
          pcsource = PCSRC_ALUOUT;
          pcen     = (state_q == ST_BEQEX) ? zero : ~zero;
        end
        ST_JEX: begin
          pcsource = PCSRC_JUMP;
          pcen     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller at BUSW = 8, 16 and 32.
module tb_mc_controller;

  // Packed control word: {memread,memwrite,alusrca,memtoreg,iord,regwrite,regdst,pcen,
  //                       pcsource[1:0],alusrcb[1:0],aluop[1:0],illegal}
  localparam logic [14:0] C_ZERO   = 15'b0;
  localparam logic [14:0] C_FRDY   = 15'b10000001_00_01_00_0;
  localparam logic [14:0] C_FWAIT  = 15'b10000000_00_01_00_0;
  localparam logic [14:0] C_DEC    = 15'b00000000_00_11_00_0;
  localparam logic [14:0] C_ILL    = 15'b00000000_00_11_00_1;
  localparam logic [14:0] C_MEMADR = 15'b00100000_00_10_00_0;
  localparam logic [14:0] C_LBRD   = 15'b10001000_00_00_00_0;
  localparam logic [14:0] C_LBWR   = 15'b00010100_00_00_00_0;
  localparam logic [14:0] C_SBWR   = 15'b01001000_00_00_00_0;
  localparam logic [14:0] C_RTEX   = 15'b00100000_00_00_10_0;
  localparam logic [14:0] C_RTWR   = 15'b00000110_00_00_00_0;
  localparam logic [14:0] C_ADWR   = 15'b00000100_00_00_00_0;
  localparam logic [14:0] C_BRT    = 15'b00100001_01_00_01_0;
  localparam logic [14:0] C_BRN    = 15'b00100000_01_00_01_0;
  localparam logic [14:0] C_JEX    = 15'b00000001_10_00_00_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [5:0] op;
  logic       zero, memready;
  logic [2:0] memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen, illegal;
  logic [1:0] pcsource [3];
  logic [1:0] alusrcb  [3];
  logic [1:0] aluop    [3];
  logic [3:0] irw8;
  logic [1:0] irw16;
  logic [0:0] irw32;

  mc_controller #(.BUSW(8)) u_d8 (
    .clk(clk), .reset(rst[0]), .op(op), .zero(zero), .memready(memready),
    .memread(memread[0]), .memwrite(memwrite[0]), .alusrca(alusrca[0]),
    .memtoreg(memtoreg[0]), .iord(iord[0]), .regwrite(regwrite[0]), .regdst(regdst[0]),
    .pcen(pcen[0]), .pcsource(pcsource[0]), .alusrcb(alusrcb[0]), .aluop(aluop[0]),
    .irwrite(irw8), .illegal(illegal[0]));

  mc_controller #(.BUSW(16)) u_d16 (
    .clk(clk), .reset(rst[1]), .op(op), .zero(zero), .memready(memready),
    .memread(memread[1]), .memwrite(memwrite[1]), .alusrca(alusrca[1]),
    .memtoreg(memtoreg[1]), .iord(iord[1]), .regwrite(regwrite[1]), .regdst(regdst[1]),
    .pcen(pcen[1]), .pcsource(pcsource[1]), .alusrcb(alusrcb[1]), .aluop(aluop[1]),
    .irwrite(irw16), .illegal(illegal[1]));

  mc_controller #(.BUSW(32)) u_d32 (
    .clk(clk), .reset(rst[2]), .op(op), .zero(zero), .memready(memready),
    .memread(memread[2]), .memwrite(memwrite[2]), .alusrca(alusrca[2]),
    .memtoreg(memtoreg[2]), .iord(iord[2]), .regwrite(regwrite[2]), .regdst(regdst[2]),
    .pcen(pcen[2]), .pcsource(pcsource[2]), .alusrcb(alusrcb[2]), .aluop(aluop[2]),
    .irwrite(irw32), .illegal(illegal[2]));

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [14:0] ctl(input int s);
    return {memread[s], memwrite[s], alusrca[s], memtoreg[s], iord[s], regwrite[s],
            regdst[s], pcen[s], pcsource[s], alusrcb[s], aluop[s], illegal[s]};
  endfunction

  function automatic logic [3:0] irw(input int s);
    case (s)
      0:       return irw8;
      1:       return {2'b00, irw16};
      default: return {3'b000, irw32};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; samples mid-cycle, then advances.
  task automatic cyc(input int s, input string tag, input logic [14:0] ectl,
                     input logic [3:0] eirw);
    #1;
    check($sformatf("%s.ctl", tag), 32'(ctl(s)), 32'(ectl));
    check($sformatf("%s.irw", tag), 32'(irw(s)), 32'(eirw));
    if (memread[s] && memwrite[s]) check($sformatf("%s.rdwr", tag), 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int s, input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(s, $sformatf("%s.f%0d", tag, i), C_FRDY, 4'(1 << i));
  endtask

  initial begin
    rst = 3'b111; op = 6'b0; zero = 1'b0; memready = 1'b1;
    @(posedge clk); #1;

    // BUSW=8: reset, then zero-wait LB (8 cycles)
    for (int i = 0; i < 3; i++) cyc(0, "rst", C_ZERO, 4'b0);
    rst[0] = 1'b0; op = 6'b100000;
    fetch(0, 4, "lb");
    cyc(0, "lb.dec", C_DEC, 4'b0);
    cyc(0, "lb.adr", C_MEMADR, 4'b0);
    cyc(0, "lb.rd",  C_LBRD, 4'b0);
    cyc(0, "lb.wr",  C_LBWR, 4'b0);

    // branches and jump
    op = 6'b000100; zero = 1'b1;
    fetch(0, 4, "beq1"); cyc(0, "beq1.dec", C_DEC, 4'b0); cyc(0, "beq1.ex", C_BRT, 4'b0);
    op = 6'b000101; zero = 1'b1;
    fetch(0, 4, "bne1"); cyc(0, "bne1.dec", C_DEC, 4'b0); cyc(0, "bne1.ex", C_BRN, 4'b0);
    zero = 1'b0;
    fetch(0, 4, "bne0"); cyc(0, "bne0.dec", C_DEC, 4'b0); cyc(0, "bne0.ex", C_BRT, 4'b0);
    op = 6'b000010;
    fetch(0, 4, "j"); cyc(0, "j.dec", C_DEC, 4'b0); cyc(0, "j.ex", C_JEX, 4'b0);

    // illegal opcode, then next fetch must start at beat 0
    op = 6'b111111;
    fetch(0, 4, "ill"); cyc(0, "ill.dec", C_ILL, 4'b0);
    op = 6'b100000;
    fetch(0, 4, "lb2");
    cyc(0, "lb2.dec", C_DEC, 4'b0);
    cyc(0, "lb2.adr", C_MEMADR, 4'b0);
    memready = 1'b0;
    cyc(0, "lb2.w0", C_LBRD, 4'b0);
    cyc(0, "lb2.w1", C_LBRD, 4'b0);
    rst[0] = 1'b1;
    cyc(0, "rstmid0", C_ZERO, 4'b0);
    memready = 1'b1;
    cyc(0, "rstmid1", C_ZERO, 4'b0);
    rst[0] = 1'b0;
    cyc(0, "rel.f0", C_FRDY, 4'b0001);
    cyc(0, "rel.f1", C_FRDY, 4'b0010);
    rst[0] = 1'b1;

    // BUSW=32: R-type (4 cycles), ADDI, zero-wait SB
    rst[2] = 1'b0; op = 6'b000000;
    fetch(2, 1, "rt");
    cyc(2, "rt.dec", C_DEC, 4'b0); cyc(2, "rt.ex", C_RTEX, 4'b0); cyc(2, "rt.wr", C_RTWR, 4'b0);
    op = 6'b001000;
    fetch(2, 1, "addi");
    cyc(2, "addi.dec", C_DEC, 4'b0); cyc(2, "addi.ex", C_MEMADR, 4'b0);
    cyc(2, "addi.wr", C_ADWR, 4'b0);
    op = 6'b101000;
    fetch(2, 1, "sb32");
    cyc(2, "sb32.dec", C_DEC, 4'b0); cyc(2, "sb32.adr", C_MEMADR, 4'b0);
    cyc(2, "sb32.wr", C_SBWR, 4'b0);
    cyc(2, "sb32.nxt", C_FRDY, 4'b0001);
    rst[2] = 1'b1;

    // BUSW=16: SB with 3 waits on beat 1 and 2 waits in SBWR
    rst[1] = 1'b0; op = 6'b101000;
    cyc(1, "sb16.f0", C_FRDY, 4'b0001);
    memready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, $sformatf("sb16.fw%0d", i), C_FWAIT, 4'b0);
    memready = 1'b1;
    cyc(1, "sb16.f1", C_FRDY, 4'b0010);
    memready = 1'b0;
    cyc(1, "sb16.dec", C_DEC, 4'b0);
    cyc(1, "sb16.adr", C_MEMADR, 4'b0);
    cyc(1, "sb16.sw0", C_SBWR, 4'b0);
    cyc(1, "sb16.sw1", C_SBWR, 4'b0);
    memready = 1'b1;
    cyc(1, "sb16.swr", C_SBWR, 4'b0);
    cyc(1, "sb16.nxt", C_FRDY, 4'b0001);
    rst[1] = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
